// File: rtl/division_seq.sv
// Signed restoring divider, one quotient bit per cycle; result = {remainder, quotient}.
// Latency 34 cycles from accepted start to done (1 cycle for divide by zero); start is ignored while busy.
module division_seq #(
  parameter int WIDTH = 32
) (
  input  logic               i_clock,
  input  logic               i_clear,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_dividend,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_by_zero,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic [CW-1:0]      r_cnt;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_zero;
  logic               r_fixed;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_trial;

  assign w_accept  = i_start && (r_state == IDLE || r_state == DONE);
  assign w_dvd_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
  assign w_dvs_mag = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;

  // Remainder stays below |divisor| <= 2^(WIDTH-1), so only the shifted value needs the extra bit.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_dvsr};
  assign w_trial = w_shift[WIDTH-1:0] - r_dvsr;

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_zero   <= 1'b0;
      r_fixed  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_dbz <= 1'b0;
        r_cnt <= '0;
        if (i_divisor == '0) begin
          // Skip the iterations and negation: the fixed result goes straight to the write stage.
          r_state  <= SIGN;
          r_fixed  <= 1'b1;
          r_zero   <= 1'b1;
          r_quo    <= '1;
          r_rem    <= i_dividend;
          r_sign_q <= 1'b0;
          r_sign_r <= 1'b0;
        end else begin
          r_state  <= CALC;
          r_fixed  <= 1'b0;
          r_zero   <= 1'b0;
          r_busy   <= 1'b1;
          r_quo    <= w_dvd_mag;
          r_rem    <= '0;
          r_dvsr   <= w_dvs_mag;
          r_sign_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
          r_sign_r <= i_dividend[WIDTH-1];
        end
      end else begin
        case (r_state)
          CALC: begin
            r_rem <= w_ge ? w_trial : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) r_state <= SIGN;
          end
          SIGN: begin
            // Negation and the result write use separate cycles so the negators do not feed o_result directly.
            if (!r_fixed) begin
              r_quo   <= r_sign_q ? -r_quo : r_quo;
              r_rem   <= r_sign_r ? -r_rem : r_rem;
              r_fixed <= 1'b1;
            end else begin
              r_result <= {r_rem, r_quo};
              r_dbz    <= r_zero;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= DONE;
            end
          end
          IDLE, DONE: ;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_result      = r_result;

endmodule

// File: tb/tb_division_seq.sv
// Bench for division_seq: directed cases plus randomized signed pairs against an arithmetic reference.
module tb_division_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [63:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  division_seq #(.WIDTH(32)) dut (
    .i_clock       (clk),
    .i_clear       (clr),
    .i_start       (start),
    .i_dividend    (dvd),
    .i_divisor     (dvs),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (dbz),
    .o_result      (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: truncating signed division using the simulator's own 64-bit arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drive one start pulse; returns at the negedge following the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; dvd = a; dvs = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dvd = $urandom; dvs = $urandom;
  endtask

  // Counts edges until done is seen (bounded); lat=60 means it never came.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    clr = 1'b1; start = 1'b1; dvd = 32'd5; dvs = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (dbz !== 1'b0) begin n_bad++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
    n_cmp++; if (result !== 64'd0) begin n_bad++; $display("FAIL reset_result got=%h exp=0", result); end
    clr = 1'b0; start = 1'b0;
  endtask

  task automatic test_signs;
    logic [31:0] ta [6] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] tb [6] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000};
    logic [63:0] te [6] = '{64'h00000002_0000000E, 64'hFFFFFFFE_FFFFFFF2, 64'h00000002_FFFFFFF2,
                            64'hFFFFFFFE_0000000E, 64'h00000000_80000000, 64'hFFFFFFFF_00000000};
    int lat, bcnt;
    for (int i = 0; i < 6; i++) begin
      launch(ta[i], tb[i]);
      wait_done(lat, bcnt);
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL sign%0d_latency got=%0d exp=34", i, lat); end
      n_cmp++; if (bcnt !== 34) begin n_bad++; $display("FAIL sign%0d_busy_cycles got=%0d exp=34", i, bcnt); end
      n_cmp++; if (result !== te[i]) begin n_bad++; $display("FAIL sign%0d_result got=%h exp=%h", i, result, te[i]); end
      n_cmp++; if (busy !== 1'b0 || dbz !== 1'b0) begin n_bad++; $display("FAIL sign%0d_flags got busy=%b dbz=%b exp=0,0", i, busy, dbz); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || result !== te[i]) begin
        n_bad++; $display("FAIL sign%0d_hold got done=%b result=%h exp done=0 result=%h", i, done, result, te[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bcnt;
    launch(32'd5, 32'd0);
    wait_done(lat, bcnt);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL dz_latency got=%0d exp=1", lat); end
    n_cmp++; if (bcnt !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL dz_busy got=%0d exp=0", bcnt); end
    n_cmp++; if (dbz !== 1'b1) begin n_bad++; $display("FAIL dz_flag got=%b exp=1", dbz); end
    n_cmp++; if (result !== 64'h00000005_FFFFFFFF) begin n_bad++; $display("FAIL dz_result got=%h exp=00000005ffffffff", result); end
    repeat (3) @(negedge clk);
    n_cmp++; if (dbz !== 1'b1) begin n_bad++; $display("FAIL dz_hold got=%b exp=1", dbz); end
    launch(32'd9, 32'd3);
    n_cmp++; if (dbz !== 1'b0) begin n_bad++; $display("FAIL dz_cleared got=%b exp=0", dbz); end
    wait_done(lat, bcnt);
    n_cmp++; if (result !== 64'h00000000_00000003 || dbz !== 1'b0) begin
      n_bad++; $display("FAIL dz_next got=%h dbz=%b exp=0000000000000003 dbz=0", result, dbz);
    end
  endtask

  task automatic test_clear_abort;
    int lat, bcnt;
    logic seen;
    launch(32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin
      n_bad++; $display("FAIL abort_flags got busy=%b done=%b dbz=%b exp=0,0,0", busy, done, dbz);
    end
    n_cmp++; if (result !== 64'd0) begin n_bad++; $display("FAIL abort_result got=%h exp=0", result); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done got=%b exp=0", seen); end
    launch(32'd1000, 32'd10);
    wait_done(lat, bcnt);
    n_cmp++; if (lat !== 34 || result !== 64'h00000000_00000064) begin
      n_bad++; $display("FAIL abort_rerun got lat=%0d result=%h exp lat=34 result=0000000000000064", lat, result);
    end
  endtask

  task automatic test_ignore_busy;
    int lat, bcnt;
    launch(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; dvd = 32'd50; dvs = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    n_cmp++; if (lat + 5 !== 34) begin n_bad++; $display("FAIL ignore_latency got=%0d exp=34", lat + 5); end
    n_cmp++; if (result !== 64'h00000002_0000000E) begin n_bad++; $display("FAIL ignore_result got=%h exp=000000020000000e", result); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    logic [63:0] exp1, exp2;
    exp1 = ref_div(32'd77, 32'hFFFFFFFB);
    exp2 = ref_div(32'hFFED2979, 32'd89);
    launch(32'd77, 32'hFFFFFFFB);
    wait_done(lat, bcnt);
    n_cmp++; if (result !== exp1) begin n_bad++; $display("FAIL b2b_first got=%h exp=%h", result, exp1); end
    start = 1'b1; dvd = 32'hFFED2979; dvs = 32'd89;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_accept got busy=%b done=%b exp=1,0", busy, done);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    n_cmp++; if (lat + 1 !== 34) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=34", lat + 1); end
    n_cmp++; if (result !== exp2) begin n_bad++; $display("FAIL b2b_second got=%h exp=%h", result, exp2); end
  endtask

  task automatic test_random;
    int lat, bcnt;
    logic [31:0] a, b;
    logic [63:0] exp;
    longint la, lb, lq, lr, chk, ar, ab;
    logic ok;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(1, 0) == 1) b = {{16{b[31]}}, b[15:0]} >>> $urandom_range(15, 0);
      if (b == 32'd0) b = 32'd1;
      exp = ref_div(a, b);
      launch(a, b);
      wait_done(lat, bcnt);
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL rand%0d_latency got=%0d exp=34", i, lat); end
      n_cmp++; if (result !== exp) begin n_bad++; $display("FAIL rand%0d_result a=%h b=%h got=%h exp=%h", i, a, b, result, exp); end
      la  = longint'($signed(a));
      lb  = longint'($signed(b));
      lq  = longint'($signed(result[31:0]));
      lr  = longint'($signed(result[63:32]));
      chk = lq * lb + lr;
      ar  = (lr < 0) ? -lr : lr;
      ab  = (lb < 0) ? -lb : lb;
      ok  = (chk[31:0] == a) && (ar < ab) && (lr == 0 || ((lr < 0) == (la < 0)));
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rand%0d_identity a=%h b=%h got=%h", i, a, b, result); end
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; dvd = '0; dvs = '0;
    test_reset;
    test_signs;
    test_div_zero;
    test_clear_abort;
    test_ignore_busy;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
